// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-to-bus bridge: FSM encoding, parameter defaults,
// and the counter-width helper.
package cpu_bus_pkg;

    localparam int DEF_AW       = 16;
    localparam int DEF_DW       = 8;
    localparam int DEF_MIN_WAIT = 0;
    localparam int DEF_TIMEOUT  = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..max; never narrower than one bit.
    function automatic int cnt_w(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser of parametrised width with synchronous active-high reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/cpu_bus_bridge.sv
// Single-master bridge: turns a CPU request into one registered bus cycle with
// minimum wait states, a bus-grant-aware timeout, and a one-cycle completion strobe.
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MIN_WAIT = DEF_MIN_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cpu_req,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dat,
    input  logic          i_cpu_we,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_cpu_rdy,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    output logic          o_we,
    output logic          o_cyc,
    input  logic [DW-1:0] i_dat,
    input  logic          i_ack,
    input  logic          i_active,
    output logic          o_timeout,
    input  logic          i_int,
    input  logic          i_nmi,
    output logic          o_int,
    output logic          o_nmi
);

    localparam int            TW      = cnt_w(TIMEOUT);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
    localparam logic [3:0]    MW4     = 4'(MIN_WAIT);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [DW-1:0] cpu_dat_q, cpu_dat_d;
    logic          rdy_q, rdy_d;
    logic          tmo_q, tmo_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [TW-1:0] tcnt_nxt;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        cpu_dat_d = cpu_dat_q;
        rdy_d     = 1'b0;
        tmo_d     = 1'b0;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        tcnt_nxt  = tcnt_q + TW'(1);

        case (state_q)
            IDLE: begin
                cyc_d = 1'b0;
                if (i_cpu_req && i_active) begin
                    addr_d  = i_cpu_addr;
                    dat_d   = i_cpu_dat;
                    we_d    = i_cpu_we;
                    cyc_d   = 1'b1;
                    wcnt_d  = MW4;
                    tcnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Without the grant nothing advances: counters hold and i_ack is ignored.
                if (i_active) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                    if (wcnt_q == 4'd0 && i_ack) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        rdy_d   = 1'b1;
                        if (!we_q) begin
                            cpu_dat_d = i_dat;
                        end
                    end else if (TIMEOUT != 0 && tcnt_nxt == TMO_LIM) begin
                        state_d = DONE;
                        cyc_d   = 1'b0;
                        rdy_d   = 1'b1;
                        tmo_d   = 1'b1;
                        if (!we_q) begin
                            cpu_dat_d = '1;
                        end
                    end else if (TIMEOUT != 0) begin
                        tcnt_d = tcnt_nxt;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            cpu_dat_q <= '0;
            rdy_q     <= 1'b0;
            tmo_q     <= 1'b0;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            cpu_dat_q <= cpu_dat_d;
            rdy_q     <= rdy_d;
            tmo_q     <= tmo_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_dat     = dat_q;
    assign o_we      = we_q;
    assign o_cyc     = cyc_q;
    assign o_cpu_dat = cpu_dat_q;
    assign o_cpu_rdy = rdy_q;
    assign o_timeout = tmo_q;

    logic [1:0] irq_sync;

    sync2 #(.W(2)) u_irq_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     ({i_nmi, i_int}),
        .o_q     (irq_sync)
    );

    assign {o_nmi, o_int} = irq_sync;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Scoreboard bench for cpu_bus_bridge: per-transaction bus schedules are scored by an
// active-cycle-counting model; a negedge monitor checks the DUT against queued results.
module tb_cpu_bus_bridge;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MW   = 2;
    localparam int TO   = 7;
    localparam int NSCH = 64;

    logic          i_clk, i_reset;
    logic          i_cpu_req, i_cpu_we;
    logic [AW-1:0] i_cpu_addr;
    logic [DW-1:0] i_cpu_dat;
    logic [DW-1:0] o_cpu_dat;
    logic          o_cpu_rdy;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_dat;
    logic          o_we, o_cyc;
    logic [DW-1:0] i_dat;
    logic          i_ack, i_active;
    logic          o_timeout;
    logic          i_int, i_nmi, o_int, o_nmi;

    cpu_bus_bridge #(.AW(AW), .DW(DW), .MIN_WAIT(MW), .TIMEOUT(TO)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cpu_req  (i_cpu_req),
        .i_cpu_addr (i_cpu_addr),
        .i_cpu_dat  (i_cpu_dat),
        .i_cpu_we   (i_cpu_we),
        .o_cpu_dat  (o_cpu_dat),
        .o_cpu_rdy  (o_cpu_rdy),
        .o_addr     (o_addr),
        .o_dat      (o_dat),
        .o_we       (o_we),
        .o_cyc      (o_cyc),
        .i_dat      (i_dat),
        .i_ack      (i_ack),
        .i_active   (i_active),
        .o_timeout  (o_timeout),
        .i_int      (i_int),
        .i_nmi      (i_nmi),
        .o_int      (o_int),
        .o_nmi      (o_nmi)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic          we;
        logic [DW-1:0] rdat;
        logic          tmo;
        int            d;
    } item_t;

    item_t         exp_q[$];
    logic          s_act[NSCH];
    logic          s_ack[NSCH];
    logic [DW-1:0] s_dat[NSCH];
    logic [DW-1:0] rd_model;
    int            mode;       // 0 scoreboard, 1 skip bus checks, 2 expect reset values
    bit            done;
    int            n_chk, n_fail;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Ack counts once more than MW granted cycles have elapsed; timeout fires on the
    // TO-th granted cycle unless an acceptable ack arrives in that same cycle.
    function automatic void predict(output int d, output logic tmo);
        int nact;
        nact = 0;
        d    = NSCH;
        tmo  = 1'b0;
        for (int j = 0; j < NSCH; j++) begin
            if (s_act[j]) begin
                nact++;
                if (nact > MW && s_ack[j]) begin
                    d = j + 1;
                    return;
                end
                if (TO > 0 && nact == TO) begin
                    d   = j + 1;
                    tmo = 1'b1;
                    return;
                end
            end
        end
    endfunction

    task automatic fill(input int kind);
        for (int j = 0; j < NSCH; j++) begin
            s_dat[j] = 8'($urandom);
            case (kind)
                1: begin s_act[j] = 1'b1; s_ack[j] = 1'b1; end
                2: begin s_act[j] = 1'b1; s_ack[j] = 1'b0; end
                3: begin s_act[j] = !(j >= 2 && j < 12); s_ack[j] = (j >= 2); end
                4: begin s_act[j] = 1'b1; s_ack[j] = (j == TO - 1); end
                5: begin s_act[j] = 1'b1; s_ack[j] = (j >= MW); s_dat[j] = 8'h5A; end
                default: begin
                    s_act[j] = (j >= 40) || ($urandom_range(0, 3) != 0);
                    s_ack[j] = ($urandom_range(0, 2) == 0);
                end
            endcase
        end
    endtask

    task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic we);
        int    d;
        logic  tmo;
        item_t it;
        predict(d, tmo);
        if (!we) rd_model = tmo ? '1 : s_dat[d-1];
        it = '{a, wd, we, rd_model, tmo, d};
        exp_q.push_back(it);
        i_cpu_req  = 1'b1;
        i_active   = 1'b1;
        i_cpu_addr = a;
        i_cpu_dat  = wd;
        i_cpu_we   = we;
        i_ack      = 1'($urandom);
        tick;
        for (int j = 0; j < d; j++) begin
            i_cpu_req  = 1'($urandom);
            i_cpu_addr = 16'($urandom);
            i_cpu_dat  = 8'($urandom);
            i_cpu_we   = 1'($urandom);
            i_active   = s_act[j];
            i_ack      = s_ack[j];
            i_dat      = s_dat[j];
            tick;
        end
        // A request offered during DONE must not start a bus cycle.
        i_cpu_req = 1'($urandom);
        i_active  = 1'b1;
        i_ack     = 1'($urandom);
        tick;
        repeat ($urandom_range(0, 2)) begin
            i_cpu_req = 1'($urandom);
            i_active  = 1'b0;
            tick;
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_int = 1'($urandom);
            i_nmi = 1'($urandom);
        end
    end

    initial begin
        i_reset = 1'b1; mode = 2; done = 1'b0; rd_model = '0;
        i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_dat = '0;
        i_dat = '0; i_ack = 1'b0; i_active = 1'b0; i_int = 1'b0; i_nmi = 1'b0;
        repeat (3) tick;
        i_reset = 1'b0;
        tick;
        mode = 0;

        fill(5); run_txn(16'h1234, 8'h00, 1'b0);
        fill(1); run_txn(16'h8000, 8'hA5, 1'b1);
        fill(2); run_txn(16'($urandom), 8'($urandom), 1'b0);
        fill(3); run_txn(16'($urandom), 8'($urandom), 1'b0);
        fill(4); run_txn(16'($urandom), 8'($urandom), 1'b0);
        fill(2); run_txn(16'($urandom), 8'($urandom), 1'b1);

        // Reset in the second WAIT cycle, with ack offered at the same edge.
        mode = 1;
        i_cpu_req = 1'b1; i_active = 1'b1; i_cpu_we = 1'b0;
        i_cpu_addr = 16'h4321; i_ack = 1'b0;
        tick;
        i_cpu_req = 1'b0;
        tick;
        i_reset = 1'b1; i_ack = 1'b1;
        tick;
        mode = 2; i_reset = 1'b0;
        repeat (3) tick;
        rd_model = '0;
        mode = 0;

        for (int n = 0; n < 150; n++) begin
            fill(0);
            run_txn(16'($urandom), 8'($urandom), 1'($urandom));
        end

        i_cpu_req = 1'b0;
        repeat (3) tick;
        done = 1'b1;
        repeat (5) tick;
        $display("FAIL end_of_run: monitor did not close the run");
        $fatal(1, "bench did not terminate");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    logic [1:0] irq_h[$];

    always @(posedge i_clk) begin
        if (i_reset) begin
            irq_h.delete();
        end else begin
            irq_h.push_back({i_nmi, i_int});
            if (irq_h.size() > 4) void'(irq_h.pop_front());
        end
    end

    logic [DW-1:0] held;
    int            cyc_cnt;
    initial begin
        held    = '0;
        cyc_cnt = 0;
        n_chk   = 0;
        n_fail  = 0;
    end

    always @(negedge i_clk) begin
        logic [1:0] irq_exp;
        item_t      it;
        irq_exp = (irq_h.size() >= 2) ? irq_h[irq_h.size()-2] : 2'b00;
        chk("irq_sync", 32'({o_nmi, o_int}), 32'(irq_exp));
        case (mode)
            2: begin
                chk("rst_cyc", 32'(o_cyc), 32'd0);
                chk("rst_addr", 32'(o_addr), 32'd0);
                chk("rst_dat", 32'(o_dat), 32'd0);
                chk("rst_we", 32'(o_we), 32'd0);
                chk("rst_cpu_dat", 32'(o_cpu_dat), 32'd0);
                chk("rst_rdy", 32'(o_cpu_rdy), 32'd0);
                chk("rst_timeout", 32'(o_timeout), 32'd0);
                held    = '0;
                cyc_cnt = 0;
            end
            0: begin
                if (exp_q.size() == 0) begin
                    chk("cyc_without_txn", 32'(o_cyc), 32'd0);
                    chk("rdy_without_txn", 32'(o_cpu_rdy), 32'd0);
                end else begin
                    if (o_cyc) begin
                        chk("bus_addr", 32'(o_addr), 32'(exp_q[0].addr));
                        chk("bus_dat", 32'(o_dat), 32'(exp_q[0].wdat));
                        chk("bus_we", 32'(o_we), 32'(exp_q[0].we));
                        cyc_cnt++;
                    end
                    if (o_cpu_rdy) begin
                        it   = exp_q.pop_front();
                        held = it.rdat;
                        chk("timeout_flag", 32'(o_timeout), 32'(it.tmo));
                        chk("cyc_length", 32'(cyc_cnt), 32'(it.d));
                        cyc_cnt = 0;
                    end
                end
                if (!o_cpu_rdy) chk("timeout_without_rdy", 32'(o_timeout), 32'd0);
                chk("cpu_dat", 32'(o_cpu_dat), 32'(held));
            end
            default: ;
        endcase
        if (done) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

endmodule
